// File: rtl/if_id_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// if_id_queue : fetch-to-decode instruction queue, flushable in one cycle.
// Revision    : 1.0
//------------------------------------------------------------------------------
module if_id_queue #(
   parameter int WORD  = 64,
   parameter int INSTR = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORD-1:0]          in_pc,
   input  logic [WORD-1:0]          in_pc_incr,
   input  logic [INSTR-1:0]         in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORD-1:0]          out_pc,
   output logic [WORD-1:0]          out_pc_incr,
   output logic [INSTR-1:0]         out_instr,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int            AW     = $clog2(DEPTH);
   localparam int            CW     = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [WORD-1:0]  r_mem_pc      [DEPTH];
   logic [WORD-1:0]  r_mem_pc_incr [DEPTH];
   logic [INSTR-1:0] r_mem_instr   [DEPTH];

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign in_ready    = (r_count != C_FULL);
   assign out_valid   = (r_count != '0);
   assign w_push      = in_valid & in_ready & ~flush;
   assign w_pop       = out_valid & out_ready & ~flush;
   assign out_pc      = r_mem_pc[r_rd_ptr];
   assign out_pc_incr = r_mem_pc_incr[r_rd_ptr];
   assign out_instr   = r_mem_instr[r_rd_ptr];
   assign count       = r_count;

   // Flush wins over any same-cycle push/pop; storage is left stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_pc[i]      <= '0;
            r_mem_pc_incr[i] <= '0;
            r_mem_instr[i]   <= '0;
         end
      end else if (w_push) begin
         r_mem_pc[r_wr_ptr]      <= in_pc;
         r_mem_pc_incr[r_wr_ptr] <= in_pc_incr;
         r_mem_instr[r_wr_ptr]   <= in_instr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_if_id_queue : scoreboard bench, directed scenarios then random traffic.
//------------------------------------------------------------------------------
module tb_if_id_queue;

   localparam int WORD  = 64;
   localparam int INSTR = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [WORD-1:0]  pc;
      logic [WORD-1:0]  pc_incr;
      logic [INSTR-1:0] instr;
   } ent_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [WORD-1:0]         in_pc = '0;
   logic [WORD-1:0]         in_pc_incr = '0;
   logic [INSTR-1:0]        in_instr = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [WORD-1:0]         out_pc;
   logic [WORD-1:0]         out_pc_incr;
   logic [INSTR-1:0]        out_instr;
   logic                    flush = 1'b0;
   logic [$clog2(DEPTH):0]  count;

   ent_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   if_id_queue #(.WORD(WORD), .INSTR(INSTR), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_pc_incr  (in_pc_incr),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_pc_incr (out_pc_incr),
      .out_instr   (out_instr),
      .flush       (flush),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // One cycle: apply inputs, predict acceptance from the model occupancy,
   // then record the accepted entry (or the flush) once the edge has passed.
   task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
      bit acc;
      @(negedge clk);
      in_valid   = v;
      in_pc      = pc;
      in_pc_incr = pc + 64'd4;
      in_instr   = ins;
      out_ready  = ordy;
      flush      = fl;
      acc = v && !fl && (exp_q.size() < DEPTH);
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      else if (acc) exp_q.push_back('{pc, pc + 64'd4, ins});
   endtask

   // Monitor: compare state and head against the model, retire popped entries.
   initial begin
      ent_t h;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("mon_count", 64'(count), 64'(exp_q.size()));
            chk("mon_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
            if (exp_q.size() != 0) begin
               h = exp_q[0];
               chk("mon_out_pc", out_pc, h.pc);
               chk("mon_out_pc_incr", out_pc_incr, h.pc_incr);
               chk("mon_out_instr", 64'(out_instr), 64'(h.instr));
               if (out_ready && !flush) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      repeat (2) drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
      chk("idle_count", 64'(count), 64'd0);

      // Fill, overfill attempt, drain in order
      for (int i = 0; i < 4; i++) drive(1'b1, 64'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      chk("full_count", 64'(count), 64'd4);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 64'h10, 32'hA000_0004, 1'b0, 1'b0);
      chk("overfill_count", 64'(count), 64'd4);
      repeat (4) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      chk("drained_count", 64'(count), 64'd0);
      chk("drained_out_valid", 64'(out_valid), 64'd0);

      // Streaming across pointer wrap
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 64'h200 + 64'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
         chk("stream_count", 64'(count), 64'd1);
         chk("stream_out_pc", out_pc, 64'h200 + 64'(4 * i));
      end
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

      // Flush colliding with push and pop
      for (int i = 0; i < 3; i++) drive(1'b1, 64'h300 + 64'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
      drive(1'b1, 64'h999, 32'hDEAD_BEEF, 1'b1, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 64'h100, 32'h1234_5678, 1'b0, 1'b0);
      chk("post_flush_pc", out_pc, 64'h100);
      chk("post_flush_instr", 64'(out_instr), 64'h1234_5678);
      drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

      // Full with simultaneous push request and pop
      for (int i = 0; i < 4; i++) drive(1'b1, 64'h400 + 64'(4 * i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
      drive(1'b1, 64'h410, 32'hE000_0004, 1'b1, 1'b0);
      chk("full_pop_count", 64'(count), 64'd3);
      drive(1'b1, 64'h414, 32'hE000_0005, 1'b1, 1'b0);
      chk("full_pushpop_count", 64'(count), 64'd3);
      repeat (3) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges
      repeat (2) drive(1'b1, 64'h500, 32'hF000_0000, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      chk("pre_areset_count", 64'(count), 64'd2);
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("areset_count", 64'(count), 64'd0);
      chk("areset_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      end
      repeat (6) drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      chk("final_count", 64'(count), 64'd0);
      @(negedge clk);
      #4;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
